// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
//   ID/EX pipeline register feeding the 32-bit ALU. It captures the decoded
//   operands, the immediate and the control from ID. It then resolves
//   EX/MEM and MEM/WB forwarding and selects either the register or the
//   immediate for operand B. It drives alu_a, alu_b and alu_op, and carries
//   the destination, write enable and store data downstream.
//
//   Optional feature macro: EX_FWD_EN
//     defined   : rs/rt operands are forwarded from EX/MEM (priority) and MEM/WB.
//     undefined : operands come straight from the ID/EX register; exm_* / wb_*
//                 inputs are ignored and hazards are left to the stall logic.
//
//   Ports
//     clk, rst                      clock, asynchronous active-high reset
//     id_valid, stall, flush        pipeline control (flush > stall > load)
//     id_rs_val, id_rt_val          register-file read data
//     id_rs, id_rt, id_rd           source / destination register indices
//     id_imm16, id_zero_ext         raw immediate and extension mode
//     id_alu_src                    1 = operand B is the immediate
//     id_alu_class, id_funct        ALU class and R-type funct field
//     id_reg_write                  instruction writes rd
//     exm_rd/exm_reg_write/exm_result   EX/MEM forwarding source
//     wb_rd/wb_reg_write/wb_data        MEM/WB forwarding source
//     alu_a, alu_b, alu_op          ALU operands and 4-bit operation
//     ex_store_data                 forwarded rt value
//     ex_rd, ex_reg_write           registered destination / write enable
//     ex_valid, ex_illegal          EX holds an instruction / unknown funct
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] id_rs_val,
  input  logic [DATA_W-1:0] id_rt_val,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [15:0]       id_imm16,
  input  logic              id_zero_ext,
  input  logic              id_alu_src,
  input  logic [1:0]        id_alu_class,
  input  logic [5:0]        id_funct,
  input  logic              id_reg_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              exm_reg_write,
  input  logic [DATA_W-1:0] exm_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_valid,
  output logic              ex_illegal
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOR = 4'd7;
  localparam logic [3:0] OP_SLT = 4'd10;

  // Returns {illegal, op}. Unknown R-type funct falls back to ADD so the ALU
  // still sees a defined operation while the illegal flag travels downstream.
  function automatic logic [4:0] decode_op(input logic [1:0] cls,
                                           input logic [5:0] funct);
    logic [4:0] r;
    r = {1'b0, OP_ADD};
    case (cls)
      2'b00: r = {1'b0, OP_ADD};
      2'b01: r = {1'b0, OP_SUB};
      2'b11: r = {1'b0, OP_SLT};
      default: begin
        case (funct)
          6'h20, 6'h21: r = {1'b0, OP_ADD};
          6'h22, 6'h23: r = {1'b0, OP_SUB};
          6'h24:        r = {1'b0, OP_AND};
          6'h25:        r = {1'b0, OP_OR};
          6'h26:        r = {1'b0, OP_XOR};
          6'h27:        r = {1'b0, OP_NOR};
          6'h2A:        r = {1'b0, OP_SLT};
          default:      r = {1'b1, OP_ADD};
        endcase
      end
    endcase
    return r;
  endfunction

  function automatic logic signed [DATA_W-1:0] extend_imm(input logic [15:0] imm,
                                                          input logic       zero_ext);
    logic signed [DATA_W-1:0] r;
    if (zero_ext) r = {{(DATA_W-16){1'b0}}, imm};
    else          r = {{(DATA_W-16){imm[15]}}, imm};
    return r;
  endfunction

  // ---- Stage p0: decode and immediate extension in ID ----
  logic [4:0]               dec_p0;
  logic signed [DATA_W-1:0] imm_p0;

  assign dec_p0 = decode_op(id_alu_class, id_funct);
  assign imm_p0 = extend_imm(id_imm16, id_zero_ext);

  // ---- Stage p1: ID/EX register ----
  logic                     vld_p1;
  logic                     reg_write_p1;
  logic                     illegal_p1;
  logic [3:0]               op_p1;
  logic [REG_AW-1:0]        rd_p1;
  logic [REG_AW-1:0]        rs_p1;
  logic [REG_AW-1:0]        rt_p1;
  logic [DATA_W-1:0]        rs_val_p1;
  logic [DATA_W-1:0]        rt_val_p1;
  logic signed [DATA_W-1:0] imm_p1;
  logic                     alu_src_p1;

  // Flush produces exactly the reset image, so a killed slot is
  // indistinguishable from a freshly reset one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      reg_write_p1 <= 1'b0;
      illegal_p1   <= 1'b0;
      op_p1        <= OP_ADD;
      rd_p1        <= '0;
      rs_p1        <= '0;
      rt_p1        <= '0;
      rs_val_p1    <= '0;
      rt_val_p1    <= '0;
      imm_p1       <= '0;
      alu_src_p1   <= 1'b0;
    end else if (flush) begin
      vld_p1       <= 1'b0;
      reg_write_p1 <= 1'b0;
      illegal_p1   <= 1'b0;
      op_p1        <= OP_ADD;
      rd_p1        <= '0;
      rs_p1        <= '0;
      rt_p1        <= '0;
      rs_val_p1    <= '0;
      rt_val_p1    <= '0;
      imm_p1       <= '0;
      alu_src_p1   <= 1'b0;
    end else if (!stall) begin
      vld_p1       <= id_valid;
      reg_write_p1 <= id_reg_write & id_valid;
      illegal_p1   <= dec_p0[4] & id_valid;
      op_p1        <= dec_p0[3:0];
      rd_p1        <= id_rd;
      rs_p1        <= id_rs;
      rt_p1        <= id_rt;
      rs_val_p1    <= id_rs_val;
      rt_val_p1    <= id_rt_val;
      imm_p1       <= imm_p0;
      alu_src_p1   <= id_alu_src;
    end
  end

  // ---- Stage p1 combinational: operand forwarding and B select ----
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;

`ifdef EX_FWD_EN
  // EX/MEM is the younger producer, so it wins over MEM/WB. Register 0 is
  // hard-wired and never forwarded. Not gated by vld_p1: a bubble's operands
  // are ignored downstream anyway.
  function automatic logic [DATA_W-1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                                input logic [DATA_W-1:0] regval,
                                                input logic              e_we,
                                                input logic [REG_AW-1:0] e_rd,
                                                input logic [DATA_W-1:0] e_val,
                                                input logic              w_we,
                                                input logic [REG_AW-1:0] w_rd,
                                                input logic [DATA_W-1:0] w_val);
    logic [DATA_W-1:0] r;
    r = regval;
    if (e_we && (e_rd != '0) && (e_rd == src))      r = e_val;
    else if (w_we && (w_rd != '0) && (w_rd == src)) r = w_val;
    return r;
  endfunction

  assign rs_fwd = fwd_sel(rs_p1, rs_val_p1, exm_reg_write, exm_rd, exm_result,
                          wb_reg_write, wb_rd, wb_data);
  assign rt_fwd = fwd_sel(rt_p1, rt_val_p1, exm_reg_write, exm_rd, exm_result,
                          wb_reg_write, wb_rd, wb_data);
`else
  assign rs_fwd = rs_val_p1;
  assign rt_fwd = rt_val_p1;

  // Forwarding inputs and source indices have no consumer in this build.
  logic unused_fwd;
  assign unused_fwd = ^{exm_rd, exm_reg_write, exm_result,
                        wb_rd, wb_reg_write, wb_data, rs_p1, rt_p1};
`endif

  assign alu_a         = rs_fwd;
  assign alu_b         = alu_src_p1 ? imm_p1 : rt_fwd;
  assign alu_op        = op_p1;
  assign ex_store_data = rt_fwd;
  assign ex_rd         = rd_p1;
  assign ex_reg_write  = reg_write_p1;
  assign ex_valid      = vld_p1;
  assign ex_illegal    = illegal_p1;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid, stall, flush;
  logic [DATA_W-1:0] id_rs_val, id_rt_val;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [15:0]       id_imm16;
  logic              id_zero_ext, id_alu_src, id_reg_write;
  logic [1:0]        id_alu_class;
  logic [5:0]        id_funct;
  logic [REG_AW-1:0] exm_rd, wb_rd;
  logic              exm_reg_write, wb_reg_write;
  logic [DATA_W-1:0] exm_result, wb_data;
  logic [DATA_W-1:0] alu_a, alu_b, ex_store_data;
  logic [3:0]        alu_op;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write, ex_valid, ex_illegal;

  int vectors = 0;
  int miscompares = 0;

  id_ex_operand_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .stall(stall), .flush(flush),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_imm16(id_imm16), .id_zero_ext(id_zero_ext),
    .id_alu_src(id_alu_src), .id_alu_class(id_alu_class), .id_funct(id_funct),
    .id_reg_write(id_reg_write), .exm_rd(exm_rd), .exm_reg_write(exm_reg_write),
    .exm_result(exm_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_valid(ex_valid), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  // Reference model: the architectural content of the EX slot.
  logic              m_valid, m_rw, m_ill, m_known, m_src;
  logic [3:0]        m_op;
  logic [REG_AW-1:0] m_rd, m_rs, m_rt;
  logic [DATA_W-1:0] m_rsv, m_rtv, m_imm;

  function automatic logic [4:0] ref_op(input logic [1:0] cls, input logic [5:0] f);
    if (cls == 2'd0) return 5'd0;
    if (cls == 2'd1) return 5'd2;
    if (cls == 2'd3) return 5'd10;
    if (f == 6'h20 || f == 6'h21) return 5'd0;
    if (f == 6'h22 || f == 6'h23) return 5'd2;
    if (f == 6'h24) return 5'd4;
    if (f == 6'h25) return 5'd5;
    if (f == 6'h26) return 5'd6;
    if (f == 6'h27) return 5'd7;
    if (f == 6'h2A) return 5'd10;
    return 5'b10000;
  endfunction

  function automatic logic [DATA_W-1:0] ref_fwd(input logic [REG_AW-1:0] src,
                                                input logic [DATA_W-1:0] regval);
`ifdef EX_FWD_EN
    if (src != 0 && exm_reg_write && exm_rd == src) return exm_result;
    if (src != 0 && wb_reg_write && wb_rd == src) return wb_data;
`endif
    return regval;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_ill = 0; m_known = 1; m_src = 0; m_op = 0;
    m_rd = 0; m_rs = 0; m_rt = 0; m_rsv = 0; m_rtv = 0; m_imm = 0;
  endtask

  task automatic model_edge();
    logic [4:0] d;
    if (flush) model_clear();
    else if (!stall) begin
      d = ref_op(id_alu_class, id_funct);
      m_valid = id_valid;
      m_rw    = id_reg_write && id_valid;
      m_ill   = d[4] && id_valid;
      m_known = id_valid;
      m_op = d[3:0]; m_rd = id_rd; m_rs = id_rs; m_rt = id_rt;
      m_rsv = id_rs_val; m_rtv = id_rt_val; m_src = id_alu_src;
      m_imm = id_zero_ext ? {16'h0, id_imm16} : {{16{id_imm16[15]}}, id_imm16};
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic quiet_fwd();
    exm_rd = 0; exm_reg_write = 0; exm_result = 0;
    wb_rd = 0; wb_reg_write = 0; wb_data = 0;
  endtask

  task automatic load_instr(input logic [1:0] cls, input logic [5:0] f,
                            input logic [DATA_W-1:0] rsv, input logic [DATA_W-1:0] rtv,
                            input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                            input logic [REG_AW-1:0] rd, input logic [15:0] imm,
                            input logic zx, input logic src);
    id_valid = 1; id_reg_write = 1; id_alu_class = cls; id_funct = f;
    id_rs_val = rsv; id_rt_val = rtv; id_rs = rs; id_rt = rt; id_rd = rd;
    id_imm16 = imm; id_zero_ext = zx; id_alu_src = src;
  endtask

  task automatic test_reset();
    // Hold something valid in EX, then assert reset between edges.
    load_instr(2'b01, 6'h0, 32'h1234, 32'h5678, 5'd4, 5'd5, 5'd6, 16'h0, 0, 0);
    quiet_fwd();
    step();
    vectors++;
    if (ex_valid !== 1'b1) begin miscompares++; $display("FAIL reset_pre_valid got=%0b exp=1", ex_valid); end
    #2 rst = 1; #1;
    model_clear();
    vectors++;
    if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%0b exp=0", ex_valid); end
    vectors++;
    if (ex_reg_write !== 1'b0) begin miscompares++; $display("FAIL reset_rw got=%0b exp=0", ex_reg_write); end
    vectors++;
    if (alu_op !== 4'd0 || ex_illegal !== 1'b0 || ex_rd !== 0) begin
      miscompares++; $display("FAIL reset_ctrl op=%0d ill=%0b rd=%0d exp 0/0/0", alu_op, ex_illegal, ex_rd);
    end
    vectors++;
    if (alu_a !== 0 || alu_b !== 0 || ex_store_data !== 0) begin
      miscompares++; $display("FAIL reset_data a=%h b=%h st=%h exp 0", alu_a, alu_b, ex_store_data);
    end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_rtype();
    logic [5:0] fs [3];
    logic [3:0] ops [3];
    logic       ills [3];
    fs = '{6'h27, 6'h2A, 6'h3F}; ops = '{4'd7, 4'd10, 4'd0}; ills = '{1'b0, 1'b0, 1'b1};
    quiet_fwd();
    for (int i = 0; i < 3; i++) begin
      load_instr(2'b10, fs[i], 32'd0, 32'd1, 5'd1, 5'd2, 5'd3, 16'h0, 0, 0);
      step();
      vectors++;
      if (alu_op !== ops[i] || ex_illegal !== ills[i]) begin
        miscompares++;
        $display("FAIL rtype_op funct=%h op=%0d ill=%0b exp op=%0d ill=%0b", fs[i], alu_op, ex_illegal, ops[i], ills[i]);
      end
      vectors++;
      if (alu_a !== 32'd0 || alu_b !== 32'd1) begin
        miscompares++; $display("FAIL rtype_opnd a=%h b=%h exp 0/1", alu_a, alu_b);
      end
    end
  endtask

  task automatic test_immediate();
    quiet_fwd();
    load_instr(2'b00, 6'h0, 32'd7, 32'd9, 5'd1, 5'd2, 5'd3, 16'hFFF4, 0, 1);
    step();
    vectors++;
    if (alu_b !== 32'hFFFF_FFF4 || alu_op !== 4'd0) begin
      miscompares++; $display("FAIL imm_sext b=%h op=%0d exp fffffff4/0", alu_b, alu_op);
    end
    vectors++;
    if (ex_store_data !== 32'd9) begin miscompares++; $display("FAIL imm_store got=%h exp 9", ex_store_data); end
    id_zero_ext = 1;
    step();
    vectors++;
    if (alu_b !== 32'h0000_FFF4) begin miscompares++; $display("FAIL imm_zext b=%h exp 0000fff4", alu_b); end
  endtask

  task automatic test_forwarding();
    logic [DATA_W-1:0] e1, e2;
    quiet_fwd();
    load_instr(2'b10, 6'h20, 32'd100, 32'd200, 5'd3, 5'd3, 5'd8, 16'h0, 0, 0);
    step();
    exm_rd = 3; exm_reg_write = 1; exm_result = 12;
    wb_rd = 3; wb_reg_write = 1; wb_data = 25;
    #1;
`ifdef EX_FWD_EN
    e1 = 12; e2 = 25;
`else
    e1 = 100; e2 = 100;
`endif
    vectors++;
    if (alu_a !== e1 || ex_store_data !== (e1 == 12 ? 32'd12 : 32'd200)) begin
      miscompares++; $display("FAIL fwd_both a=%0d st=%0d exp a=%0d", alu_a, ex_store_data, e1);
    end
    exm_reg_write = 0; #1;
    vectors++;
    if (alu_a !== e2) begin miscompares++; $display("FAIL fwd_wb a=%0d exp %0d", alu_a, e2); end
    exm_reg_write = 1;
    load_instr(2'b10, 6'h20, 32'd100, 32'd200, 5'd0, 5'd0, 5'd8, 16'h0, 0, 0);
    exm_rd = 0; wb_rd = 0;
    step();
    vectors++;
    if (alu_a !== 32'd100 || ex_store_data !== 32'd200) begin
      miscompares++; $display("FAIL fwd_r0 a=%0d st=%0d exp 100/200", alu_a, ex_store_data);
    end
    quiet_fwd();
  endtask

  task automatic test_stall_flush();
    quiet_fwd();
    load_instr(2'b01, 6'h0, 32'hAAAA, 32'hBBBB, 5'd1, 5'd2, 5'd9, 16'h0, 0, 0);
    step();
    load_instr(2'b10, 6'h25, 32'hCCCC, 32'hDDDD, 5'd1, 5'd2, 5'd17, 16'h0, 0, 0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd9 || alu_op !== 4'd2 || alu_a !== 32'hAAAA) begin
        miscompares++;
        $display("FAIL stall_hold cyc=%0d v=%0b rd=%0d op=%0d a=%h exp 1/9/2/aaaa", i, ex_valid, ex_rd, alu_op, alu_a);
      end
    end
    flush = 1;
    step();
    vectors++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
      miscompares++; $display("FAIL stall_flush v=%0b rw=%0b exp 0/0", ex_valid, ex_reg_write);
    end
    stall = 0; flush = 0;
    step();
    vectors++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd17 || alu_op !== 4'd5 || alu_a !== 32'hCCCC) begin
      miscompares++; $display("FAIL stall_release v=%0b rd=%0d op=%0d a=%h exp 1/17/5/cccc", ex_valid, ex_rd, alu_op, alu_a);
    end
  endtask

  task automatic test_bubble();
    quiet_fwd();
    load_instr(2'b10, 6'h3F, 32'd1, 32'd2, 5'd1, 5'd2, 5'd3, 16'h0, 0, 0);
    id_valid = 0;
    step();
    vectors++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_illegal !== 1'b0) begin
      miscompares++; $display("FAIL bubble v=%0b rw=%0b ill=%0b exp 0/0/0", ex_valid, ex_reg_write, ex_illegal);
    end
  endtask

  task automatic test_random();
    logic [5:0] ftab [9];
    logic [DATA_W-1:0] ea, eb, es;
    ftab = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
    for (int i = 0; i < 300; i++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      id_rs_val = $urandom(); id_rt_val = $urandom();
      id_rs = $urandom_range(0, 7); id_rt = $urandom_range(0, 7); id_rd = $urandom();
      id_imm16 = $urandom(); id_zero_ext = $urandom(); id_alu_src = $urandom();
      id_alu_class = $urandom(); id_reg_write = $urandom();
      id_funct = ($urandom_range(0, 4) == 0) ? 6'($urandom()) : ftab[$urandom_range(0, 8)];
      for (int k = 0; k < 2; k++) begin
        exm_rd = $urandom_range(0, 7); exm_reg_write = $urandom(); exm_result = $urandom();
        wb_rd = $urandom_range(0, 7); wb_reg_write = $urandom(); wb_data = $urandom();
        if (k == 0) step(); else #1;
        vectors++;
        if (ex_valid !== m_valid || ex_reg_write !== m_rw || ex_illegal !== m_ill) begin
          miscompares++;
          $display("FAIL rnd_ctrl it=%0d v=%0b rw=%0b ill=%0b exp %0b/%0b/%0b", i, ex_valid, ex_reg_write, ex_illegal, m_valid, m_rw, m_ill);
        end
        if (m_known) begin
          ea = ref_fwd(m_rs, m_rsv);
          es = ref_fwd(m_rt, m_rtv);
          eb = m_src ? m_imm : es;
          vectors++;
          if (alu_op !== m_op || ex_rd !== m_rd) begin
            miscompares++; $display("FAIL rnd_op it=%0d op=%0d rd=%0d exp %0d/%0d", i, alu_op, ex_rd, m_op, m_rd);
          end
          vectors++;
          if (alu_a !== ea || alu_b !== eb || ex_store_data !== es) begin
            miscompares++;
            $display("FAIL rnd_opnd it=%0d a=%h b=%h st=%h exp %h/%h/%h", i, alu_a, alu_b, ex_store_data, ea, eb, es);
          end
        end
      end
    end
    stall = 0; flush = 0;
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0; id_valid = 0;
    id_rs_val = 0; id_rt_val = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_imm16 = 0; id_zero_ext = 0; id_alu_src = 0; id_alu_class = 0;
    id_funct = 0; id_reg_write = 0;
    quiet_fwd();
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    test_reset();
    test_rtype();
    test_immediate();
    test_forwarding();
    test_stall_flush();
    test_bubble();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
